// File: rtl/bus_slave_mem.sv
// Serial-bus slave memory: bit-serial address/burst/data in, bit-serial read data out,
// with optional per-word access latency and a split indication during read waits.
module bus_slave_mem #(
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int MEM_DEPTH   = 4096,
  parameter int BURST_LEN   = 12,
  parameter int WAIT_CYCLES = 0,
  parameter int SPLIT_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       master_valid,
  input  logic       master_ready,
  input  logic       read_en,
  input  logic       write_en,
  input  logic       rx_address,
  input  logic       rx_burst,
  input  logic       rx_data,
  output logic       tx_data,
  output logic       slave_valid,
  output logic       slave_ready,
  output logic       split_en,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int CNT_MAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);
  localparam logic [5:0]       WAIT_LAST = (WAIT_CYCLES == 0) ? 6'd0 : 6'(WAIT_CYCLES - 1);
  localparam bit               HAS_WAIT  = (WAIT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WWAIT = 3'd3,
    S_RWAIT = 3'd4,
    S_RDATA = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [5:0]           wait_q, wait_d;
  logic [ADDR_LEN-1:0]  addr_q, addr_d;
  logic [BURST_LEN-1:0] burst_q, burst_d;
  logic [BURST_LEN-1:0] words_q, words_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_LEN-1:0]  shift_q, shift_d;
  logic                 is_read_q, is_read_d;
  logic                 mem_we;
  logic                 load_rd;

  logic [DATA_LEN-1:0]  mem [MEM_DEPTH];

  // Handshake: a serial input bit is consumed on a rising edge where master_valid and
  // slave_ready are both high; a read bit is consumed where slave_valid and master_ready are high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    words_d   = words_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    is_read_d = is_read_q;
    mem_we    = 1'b0;
    load_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (master_valid && (read_en ^ write_en)) begin
          state_d    = S_ADDR;
          is_read_d  = read_en;
          cnt_d      = CNT_W'(1);
          addr_d     = '0;
          addr_d[0]  = rx_address;
          burst_d    = '0;
          burst_d[0] = rx_burst;
        end
      end
      S_ADDR: begin
        if (master_valid) begin
          for (int i = 0; i < ADDR_LEN; i++)
            if (cnt_q == CNT_W'(i)) addr_d[i] = rx_address;
          for (int i = 0; i < BURST_LEN; i++)
            if (cnt_q == CNT_W'(i)) burst_d[i] = rx_burst;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            wait_d  = '0;
            words_d = (burst_d == '0) ? BURST_LEN'(1) : burst_d;
            idx_d   = addr_d[IDX_W-1:0];
            if (!is_read_q) begin
              state_d = S_WDATA;
            end else if (HAS_WAIT) begin
              state_d = S_RWAIT;
            end else begin
              state_d = S_RDATA;
              load_rd = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (master_valid) begin
          shift_d = {rx_data, shift_q[DATA_LEN-1:1]};
          if (cnt_q == DATA_LAST) begin
            cnt_d  = '0;
            wait_d = '0;
            if (HAS_WAIT) begin
              state_d = S_WWAIT;
            end else begin
              mem_we = 1'b1;
              if (words_q == BURST_LEN'(1)) begin
                state_d = S_IDLE;
              end else begin
                words_d = words_q - 1'b1;
                idx_d   = idx_q + 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WWAIT: begin
        if (wait_q == WAIT_LAST) begin
          mem_we = 1'b1;
          if (words_q == BURST_LEN'(1)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WDATA;
            words_d = words_q - 1'b1;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RWAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_RDATA;
          load_rd = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RDATA: begin
        if (master_ready) begin
          shift_d = shift_q >> 1;
          if (cnt_q == DATA_LAST) begin
            cnt_d  = '0;
            wait_d = '0;
            if (words_q == BURST_LEN'(1)) begin
              state_d = S_IDLE;
            end else begin
              words_d = words_q - 1'b1;
              idx_d   = idx_q + 1'b1;
              if (HAS_WAIT) begin
                state_d = S_RWAIT;
              end else begin
                load_rd = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      words_q   <= '0;
      idx_q     <= '0;
      is_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      words_q   <= words_d;
      idx_q     <= idx_d;
      is_read_q <= is_read_d;
    end
  end

  // The shift register doubles as the RAM's registered read port: a load reads the word
  // at the index that becomes current on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         shift_q <= '0;
    else if (load_rd) shift_q <= mem[idx_d];
    else              shift_q <= shift_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= shift_d;
  end

  assign slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign slave_valid = (state_q == S_RDATA);
  assign tx_data     = slave_valid & shift_q[0];
  assign split_en    = (SPLIT_EN != 0) && (state_q == S_RWAIT);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: a zero-latency instance and a 4-cycle-latency
// split-enabled instance share the stimulus; a select picks which one is observed.
module tb_bus_slave_mem;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WWAIT = 3'd3;

  logic clk = 1'b0;
  logic rst, master_valid, master_ready, read_en, write_en, rx_address, rx_burst, rx_data;
  logic tx0, sv0, sr0, sp0, bz0, tx1, sv1, sr1, sp1, bz1;
  logic [2:0] st0, st1;
  logic sel;
  logic obs_tx, obs_valid, obs_ready, obs_split, obs_busy;
  logic [2:0] obs_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_slave_mem u_dut0 (
    .clk(clk), .rst(rst), .master_valid(master_valid), .master_ready(master_ready),
    .read_en(read_en), .write_en(write_en), .rx_address(rx_address), .rx_burst(rx_burst),
    .rx_data(rx_data), .tx_data(tx0), .slave_valid(sv0), .slave_ready(sr0),
    .split_en(sp0), .busy(bz0), .dbg_state_o(st0)
  );

  bus_slave_mem #(.WAIT_CYCLES(4), .SPLIT_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .master_valid(master_valid), .master_ready(master_ready),
    .read_en(read_en), .write_en(write_en), .rx_address(rx_address), .rx_burst(rx_burst),
    .rx_data(rx_data), .tx_data(tx1), .slave_valid(sv1), .slave_ready(sr1),
    .split_en(sp1), .busy(bz1), .dbg_state_o(st1)
  );

  assign obs_tx    = sel ? tx1 : tx0;
  assign obs_valid = sel ? sv1 : sv0;
  assign obs_ready = sel ? sr1 : sr0;
  assign obs_split = sel ? sp1 : sp0;
  assign obs_busy  = sel ? bz1 : bz0;
  assign obs_state = sel ? st1 : st0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, obs_ready, 1);
    chk({tag, "_valid"}, obs_valid, 0);
    chk({tag, "_tx"},    obs_tx,    0);
    chk({tag, "_split"}, obs_split, 0);
    chk({tag, "_busy"},  obs_busy,  0);
    chk({tag, "_state"}, obs_state, ST_IDLE);
  endtask

  // Enables are flipped after the start bit to show they are latched.
  task automatic send_header(input bit is_read, input logic [11:0] addr,
                             input logic [11:0] burst, input int stall_at);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == stall_at) begin
        master_valid = 1'b0;
        rx_address   = ~addr[i];
        rx_burst     = ~burst[i];
        repeat (3) @(negedge clk);
        chk("addr_stall_state", obs_state, ST_ADDR);
      end
      master_valid = 1'b1;
      read_en      = (i == 0) ? is_read : !is_read;
      write_en     = (i == 0) ? !is_read : is_read;
      rx_address   = addr[i];
      rx_burst     = burst[i];
    end
  endtask

  task automatic wait_ready(input int exp_cycles, input string tag);
    int k = 0;
    while (obs_ready !== 1'b1 && k < 100) begin
      chk({tag, "_wwait_state"}, obs_state, ST_WWAIT);
      k++;
      @(negedge clk);
    end
    chk({tag, "_wwait_len"}, k, exp_cycles);
  endtask

  task automatic write_words(input int n, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input int exp_wait, input string tag);
    logic [7:0] words [3];
    words[0] = w0; words[1] = w1; words[2] = w2;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        if (b == 0 && w > 0) wait_ready(exp_wait, tag);
        if (b == 0) chk({tag, "_wdata_state"}, obs_state, ST_WDATA);
        master_valid = 1'b1;
        rx_data      = words[w][b];
      end
    end
    @(negedge clk);
    master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0; rx_data = 1'b0;
    wait_ready(exp_wait, tag);
    chk({tag, "_done_busy"}, obs_busy, 0);
  endtask

  task automatic read_words(input int n, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input int exp_wait, input logic exp_split,
                            input int stall_bit, input string tag);
    logic [7:0] exp_w [3];
    logic [7:0] got;
    int k;
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2;
    @(negedge clk);
    master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0; master_ready = 1'b0;
    for (int w = 0; w < n; w++) begin
      k = 0;
      while (obs_valid !== 1'b1 && k < 100) begin
        chk({tag, "_rwait_ready"}, obs_ready, 0);
        chk({tag, "_rwait_split"}, obs_split, exp_split);
        master_ready = 1'b0;
        k++;
        @(negedge clk);
      end
      chk({tag, "_rwait_len"}, k, exp_wait);
      got = '0;
      for (int b = 0; b < 8; b++) begin
        if (b == stall_bit) begin
          master_ready = 1'b0;
          repeat (3) @(negedge clk);
          chk({tag, "_stall_valid"}, obs_valid, 1);
          chk({tag, "_stall_tx"}, obs_tx, exp_w[w][b]);
        end
        if (b == 0) chk({tag, "_rdata_split"}, obs_split, 0);
        got[b]       = obs_tx;
        master_ready = 1'b1;
        @(negedge clk);
      end
      chk({tag, "_word"}, got, exp_w[w]);
    end
    master_ready = 1'b0;
    chk({tag, "_valid_drop"}, obs_valid, 0);
    chk({tag, "_done_busy"}, obs_busy, 0);
  endtask

  initial begin
    rst = 1'b0; master_valid = 1'b0; master_ready = 1'b0; read_en = 1'b0; write_en = 1'b0;
    rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0; sel = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // single write then read
    send_header(1'b0, 12'h005, 12'd1, -1);
    write_words(1, 8'hA5, 8'h00, 8'h00, 0, "w005");
    send_header(1'b1, 12'h005, 12'd1, -1);
    read_words(1, 8'hA5, 8'h00, 8'h00, 0, 1'b0, -1, "r005");

    // burst with index wrap, then single reads; burst value 0 means one word
    send_header(1'b0, 12'hFFF, 12'd3, -1);
    write_words(3, 8'h11, 8'h22, 8'h33, 0, "wfff");
    send_header(1'b1, 12'hFFF, 12'd3, -1);
    read_words(3, 8'h11, 8'h22, 8'h33, 0, 1'b0, -1, "rfff");
    send_header(1'b1, 12'h000, 12'd0, -1);
    read_words(1, 8'h22, 8'h00, 8'h00, 0, 1'b0, -1, "r000");
    send_header(1'b1, 12'h001, 12'd1, -1);
    read_words(1, 8'h33, 8'h00, 8'h00, 0, 1'b0, -1, "r001");

    // stalls in address phase and read data phase
    send_header(1'b0, 12'h123, 12'd1, 5);
    write_words(1, 8'h5A, 8'h00, 8'h00, 0, "w123");
    send_header(1'b1, 12'h123, 12'd1, 7);
    read_words(1, 8'h5A, 8'h00, 8'h00, 0, 1'b0, 3, "r123");

    // both enables at start: ignored
    @(negedge clk);
    master_valid = 1'b1; read_en = 1'b1; write_en = 1'b1; rx_address = 1'b1; rx_burst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("both_en_busy", obs_busy, 0);
      chk("both_en_state", obs_state, ST_IDLE);
    end
    master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;

    // reset in the middle of a write leaves the old word intact
    send_header(1'b0, 12'h010, 12'd1, -1);
    write_words(1, 8'h3C, 8'h00, 8'h00, 0, "w010");
    send_header(1'b0, 12'h010, 12'd1, -1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      master_valid = 1'b1;
      rx_data      = b[0] ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    chk("pre_rst_busy", obs_busy, 1);
    #1 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0; rx_data = 1'b0;
    rst = 1'b1;
    send_header(1'b1, 12'h010, 12'd1, -1);
    read_words(1, 8'h3C, 8'h00, 8'h00, 0, 1'b0, -1, "r010");

    // latency instance: 4 wait cycles per word with split during read waits
    @(negedge clk);
    rst = 1'b0; sel = 1'b1;
    #1 chk_reset_outputs("b_rst");
    @(negedge clk);
    rst = 1'b1;
    send_header(1'b0, 12'h040, 12'd2, -1);
    write_words(2, 8'h96, 8'h69, 8'h00, 4, "w040");
    send_header(1'b1, 12'h040, 12'd2, -1);
    read_words(2, 8'h96, 8'h69, 8'h00, 4, 1'b1, -1, "r040");
    @(negedge clk);
    chk("b_idle_split", obs_split, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
